// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller. Handles data-cache miss stalls
//                (RUN / MISS_WAIT / MISS_FILL), load-use bubbles and taken
//                branch flushes. Keeps saturating performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_RS1addr_i,
    input  logic [4:0]       IF_ID_RS2addr_i,
    input  logic [4:0]       ID_EX_RDaddr_i,
    input  logic             ID_EX_MemRead_i,
    input  logic             Branch_taken_i,
    input  logic             dcache_miss_i,
    input  logic             mem_ack_i,
    output logic             PCWrite_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Bubble_o,
    output logic             Pipe_Stall_o,
    output logic             mem_req_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] loaduse_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MISS_WAIT = 2'd1,
        MISS_FILL = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] loaduse_cnt_q, loaduse_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             load_use;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Load-use: the load in EX writes a nonzero register read by the ID instruction.
    always_comb begin
        load_use = ID_EX_MemRead_i && (ID_EX_RDaddr_i != 5'd0) &&
                   ((ID_EX_RDaddr_i == IF_ID_RS1addr_i) ||
                    (ID_EX_RDaddr_i == IF_ID_RS2addr_i));
    end

    // Pipeline control outputs; priority is miss stall > load-use > branch flush.
    always_comb begin
        PCWrite_o      = 1'b1;
        IF_ID_Write_o  = 1'b1;
        IF_ID_Flush_o  = 1'b0;
        ID_EX_Bubble_o = 1'b0;
        Pipe_Stall_o   = 1'b0;
        if (!rst_i) begin
            if ((state_q != RUN) || dcache_miss_i) begin
                Pipe_Stall_o  = 1'b1;
                PCWrite_o     = 1'b0;
                IF_ID_Write_o = 1'b0;
            end else if (load_use) begin
                PCWrite_o      = 1'b0;
                IF_ID_Write_o  = 1'b0;
                ID_EX_Bubble_o = 1'b1;
            end else if (Branch_taken_i) begin
                IF_ID_Flush_o = 1'b1;
            end
        end
    end

    // Next-state for the miss sequencer, refill request and counters.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        stall_cnt_d   = stall_cnt_q;
        loaduse_cnt_d = loaduse_cnt_q;
        miss_cnt_d    = miss_cnt_q;

        case (state_q)
            RUN: begin
                if (dcache_miss_i) begin
                    state_d   = MISS_WAIT;
                    mem_req_d = 1'b1;
                end
            end
            MISS_WAIT: begin
                if (mem_ack_i) begin
                    state_d   = MISS_FILL;
                    mem_req_d = 1'b0;
                end
            end
            MISS_FILL: begin
                // One fill cycle, then resume; a miss presented here is ignored.
                state_d    = RUN;
                miss_cnt_d = sat_inc(miss_cnt_q);
            end
            default: begin
                state_d   = RUN;
                mem_req_d = 1'b0;
            end
        endcase

        if (Pipe_Stall_o) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (ID_EX_Bubble_o) begin
            loaduse_cnt_d = sat_inc(loaduse_cnt_q);
        end
    end

    // State register; reset wins over any in-flight miss or acknowledge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= RUN;
            mem_req_q     <= 1'b0;
            stall_cnt_q   <= '0;
            loaduse_cnt_q <= '0;
            miss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            stall_cnt_q   <= stall_cnt_d;
            loaduse_cnt_q <= loaduse_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign mem_req_o      = mem_req_q;
    assign stall_cycles_o = stall_cnt_q;
    assign loaduse_cnt_o  = loaduse_cnt_q;
    assign miss_cnt_o     = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Scoreboard bench for hazard_ctrl. Two instances (default
//                and 4-bit counters) share stimulus; a reference model queues
//                expected outputs per cycle, a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       mr, br, miss, ack;

    logic        pcw32, ifw32, fl32, bub32, st32, mreq32;
    logic [31:0] sc32, lc32, mc32;
    logic        pcw4, ifw4, fl4, bub4, st4, mreq4;
    logic [3:0]  sc4, lc4, mc4;

    always #5 clk = ~clk;

    hazard_ctrl u_dut32 (
        .clk_i(clk), .rst_i(rst),
        .IF_ID_RS1addr_i(rs1), .IF_ID_RS2addr_i(rs2),
        .ID_EX_RDaddr_i(rd), .ID_EX_MemRead_i(mr),
        .Branch_taken_i(br), .dcache_miss_i(miss), .mem_ack_i(ack),
        .PCWrite_o(pcw32), .IF_ID_Write_o(ifw32), .IF_ID_Flush_o(fl32),
        .ID_EX_Bubble_o(bub32), .Pipe_Stall_o(st32), .mem_req_o(mreq32),
        .stall_cycles_o(sc32), .loaduse_cnt_o(lc32), .miss_cnt_o(mc32)
    );

    hazard_ctrl #(.CNT_W(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst),
        .IF_ID_RS1addr_i(rs1), .IF_ID_RS2addr_i(rs2),
        .ID_EX_RDaddr_i(rd), .ID_EX_MemRead_i(mr),
        .Branch_taken_i(br), .dcache_miss_i(miss), .mem_ack_i(ack),
        .PCWrite_o(pcw4), .IF_ID_Write_o(ifw4), .IF_ID_Flush_o(fl4),
        .ID_EX_Bubble_o(bub4), .Pipe_Stall_o(st4), .mem_req_o(mreq4),
        .stall_cycles_o(sc4), .loaduse_cnt_o(lc4), .miss_cnt_o(mc4)
    );

    typedef struct {
        string            tag;
        logic [5:0]       ctl;     // {pcw, ifw, flush, bubble, stall, mem_req}
        longint unsigned  n_stall;
        longint unsigned  n_lu;
        longint unsigned  n_miss;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: a miss is an outstanding transaction that awaits its
    // acknowledge, then costs one more fill cycle before the pipe resumes.
    bit              miss_open   = 0;   // request issued, ack not yet seen
    bit              fill_now    = 0;   // the one post-ack fill cycle
    longint unsigned cnt_stall   = 0;
    longint unsigned cnt_lu      = 0;
    longint unsigned cnt_miss    = 0;

    function automatic longint unsigned sat(longint unsigned v, int w);
        longint unsigned lim = (64'd1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic step(input string tag, input bit r, input bit m, input bit a,
                        input bit ld, input bit b, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2);
        exp_t e;
        bit stall, hz, bubble, flush, go;
        @(posedge clk);
        #1;
        rst = r; miss = m; ack = a; mr = ld; br = b; rd = d; rs1 = s1; rs2 = s2;

        hz     = ld && (d != 0) && ((d == s1) || (d == s2));
        stall  = !r && (miss_open || fill_now || m);
        bubble = !r && !stall && hz;
        flush  = !r && !stall && !hz && b;
        go     = r || (!stall && !hz);
        e.tag     = tag;
        e.ctl     = {go, go, flush, bubble, stall, miss_open};
        e.n_stall = cnt_stall;
        e.n_lu    = cnt_lu;
        e.n_miss  = cnt_miss;
        exp_q.push_back(e);

        if (r) begin
            miss_open = 0; fill_now = 0;
            cnt_stall = 0; cnt_lu = 0; cnt_miss = 0;
        end else begin
            if (stall)  cnt_stall++;
            if (bubble) cnt_lu++;
            if (fill_now) begin
                fill_now = 0;
                cnt_miss++;
            end else if (miss_open) begin
                if (a) begin
                    miss_open = 0;
                    fill_now  = 1;
                end
            end else if (m) begin
                miss_open = 1;
            end
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    // Monitor: both instances present a full output set every cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [5:0] a32, a4;
            bit ok;
            e   = exp_q.pop_front();
            a32 = {pcw32, ifw32, fl32, bub32, st32, mreq32};
            a4  = {pcw4, ifw4, fl4, bub4, st4, mreq4};
            ok  = (a32 == e.ctl) && (a4 == e.ctl) &&
                  (64'(sc32) == sat(e.n_stall, 32)) && (64'(lc32) == sat(e.n_lu, 32)) &&
                  (64'(mc32) == sat(e.n_miss, 32)) &&
                  (64'(sc4) == sat(e.n_stall, 4)) && (64'(lc4) == sat(e.n_lu, 4)) &&
                  (64'(mc4) == sat(e.n_miss, 4));
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL %s t=%0t ctl32=%b ctl4=%b want=%b cnt32=%0d/%0d/%0d cnt4=%0d/%0d/%0d want=%0d/%0d/%0d",
                         e.tag, $time, a32, a4, e.ctl, sc32, lc32, mc32, sc4, lc4, mc4,
                         e.n_stall, e.n_lu, e.n_miss);
            end
        end
    end

    initial begin
        rst = 1; miss = 0; ack = 0; mr = 0; br = 0; rd = 0; rs1 = 0; rs2 = 0;
        repeat (2) @(posedge clk);

        idle("reset_state", 2);

        // load-use hit, then same pattern with rd=0
        step("loaduse", 0, 0, 0, 1, 0, 5'd5, 5'd5, 5'd0);
        idle("loaduse_after", 1);
        step("loaduse_rd0", 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        step("loaduse_rs2", 0, 0, 0, 1, 0, 5'd7, 5'd1, 5'd7);

        // miss at cycle 0, ack at cycle 4
        step("miss_c0", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        for (int i = 1; i <= 3; i++) step("miss_wait", 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("miss_ack", 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        step("miss_fill", 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        idle("miss_done", 2);

        // priority cases and branch-only
        step("prio_all", 0, 1, 0, 1, 1, 5'd3, 5'd3, 5'd3);
        step("prio_wait", 0, 0, 1, 1, 1, 5'd3, 5'd3, 5'd3);
        step("prio_fill", 0, 0, 0, 1, 1, 5'd3, 5'd3, 5'd3);
        step("lu_branch", 0, 0, 0, 1, 1, 5'd9, 5'd2, 5'd9);
        step("branch", 0, 0, 0, 0, 1, 5'd9, 5'd2, 5'd9);
        idle("branch_after", 1);

        // reset in MISS_WAIT with a coincident ack
        step("rst_miss", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("rst_wait", 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("rst_hit", 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        idle("rst_after", 3);

        // 20 stall cycles: 4-bit counter must stick at 15
        step("sat_miss", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 19; i++) step("sat_wait", 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("sat_ack", 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        idle("sat_hold", 4);

        // randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 600; i++) begin
            step("random",
                 ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)));
        end
        idle("drain", 1);

        @(posedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
